fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter WORD_SIZE, default 16, datapath and address width.
REQ-002 Parameter RESET_PC, default 16'h0000, first fetch address after reset.
REQ-003 clk  input  1  rising-edge clock; reset is synchronous, active-low reset_n.
REQ-004 reset_n  input  1  synchronous active-low reset.
REQ-005 i_readM  output  1  instruction-memory read request, held high until i_ready.
REQ-006 i_address  output  WORD_SIZE  fetch address, stable while i_readM high.
REQ-007 i_data  input  WORD_SIZE  instruction word, valid when i_ready high.
REQ-008 i_ready  input  1  memory completion strobe, at least 1 cycle after request.
REQ-009 bp_pc  output  WORD_SIZE  address of the fetch in flight, to branch predictor.
REQ-010 bp_predicted_pc  input  WORD_SIZE  combinational predicted next PC for bp_pc.
REQ-011 stall_id  input  1  ID cannot consume IF/ID this cycle.
REQ-012 redirect  input  1  flush request from ID (jump) or EX (mispredict).
REQ-013 redirect_pc  input  WORD_SIZE  corrected fetch address, valid with redirect.
REQ-014 ifid_valid / ifid_pc / ifid_instr / ifid_pred_pc  output  1/WORD_SIZE x3  IF/ID latch: valid, fetched PC, instruction, predicted next PC.

Function
REQ-015 Registers: pc (next address to request), req_addr (address in flight), hold buffer (instr, pc, pred_pc), FSM state.
REQ-016 FSM states: WAIT (post-reset), FETCH, HOLD, DROP; WAIT -> FETCH unconditionally after one cycle.
REQ-017 FETCH: i_readM=1, i_address=req_addr=bp_pc; req_addr loads pc when a new request starts.
REQ-018 next_pc = bp_predicted_pc (REQ-032), sampled in the i_ready cycle; unsigned modulo 2^WORD_SIZE, 16'hFFFF+1 = 16'h0000.
REQ-019 IF/ID free = !ifid_valid || !stall_id.
REQ-020 FETCH, i_ready, no redirect, IF/ID free: IF/ID <= {1, req_addr, i_data, next_pc}; pc <= next_pc; new request next cycle (back-to-back, 1 instr/cycle with 1-cycle memory).
REQ-021 FETCH, i_ready, no redirect, IF/ID not free: hold buffer <= fetch; -> HOLD; i_readM=0 in HOLD.
REQ-022 HOLD, IF/ID free, no redirect: IF/ID <= hold buffer; pc <= held pred_pc; -> FETCH.
REQ-023 IF/ID with valid && stall_id and no redirect retains all fields unchanged.
REQ-024 IF/ID free and nothing delivered: ifid_valid <= 0 (bubble).
REQ-025 redirect has priority over every other event: ifid_valid <= 0, pc <= redirect_pc, hold buffer discarded.
REQ-026 redirect in FETCH with i_ready same cycle: returned word discarded, stay FETCH, next request at redirect_pc.
REQ-027 redirect in FETCH without i_ready: -> DROP; i_readM and i_address held at req_addr until i_ready.
REQ-028 DROP: on i_ready, word discarded, -> FETCH; further redirect in DROP overwrites pc, stays DROP.
REQ-029 Redirect in HOLD or WAIT: -> FETCH at redirect_pc.

Reset
REQ-030 reset_n low at clk edge: state=WAIT, pc=RESET_PC, req_addr=RESET_PC, ifid_valid=0, ifid_pc/instr/pred_pc=0, hold buffer=0, i_readM=0.
REQ-031 Reset mid-request abandons the request; a late i_ready after reset in WAIT is ignored.

Configuration
REQ-032 Macro FETCH_PREDICT_EN: defined -> next_pc = bp_predicted_pc; undefined -> next_pc = req_addr+1, bp_predicted_pc ignored, bp_pc still driven.

Verification
REQ-033 Reset, 1-cycle memory, no stalls, predictor returns pc+1 -> i_address 0,1,2,3 on consecutive cycles; ifid_pc 0,1,2 one cycle later.
REQ-034 FETCH_PREDICT_EN, bp_predicted_pc=16'h0040 for pc 2 -> ifid_pred_pc=16'h0040 for pc 2, next i_address=16'h0040; undefined -> 16'h0003.
REQ-035 stall_id high 3 cycles with ifid_valid=1 -> IF/ID unchanged, one word in HOLD, i_readM=0; on release each word reaches ID once, in order, no loss/duplication.
REQ-036 3-cycle memory, redirect to 16'h0100 in request cycle 1 -> i_address held until i_ready, word dropped, next request 16'h0100, ifid_valid=0 meanwhile.
REQ-037 redirect and i_ready same cycle, plus redirect in HOLD -> both words discarded; next fetch at redirect_pc.
REQ-038 pc=16'hFFFF without prediction -> next i_address=16'h0000; reset_n low mid-request -> all REQ-030 values next cycle.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: instruction memory, branch predictor and IF/ID signals.
// master = fetch unit, slave = environment (memory, predictor, ID/EX).
interface fetch_unit_if #(
  parameter int WORD_SIZE = 16
);
  logic                 i_readM;
  logic [WORD_SIZE-1:0] i_address;
  logic [WORD_SIZE-1:0] i_data;
  logic                 i_ready;
  logic [WORD_SIZE-1:0] bp_pc;
  logic [WORD_SIZE-1:0] bp_predicted_pc;
  logic                 stall_id;
  logic                 redirect;
  logic [WORD_SIZE-1:0] redirect_pc;
  logic                 ifid_valid;
  logic [WORD_SIZE-1:0] ifid_pc;
  logic [WORD_SIZE-1:0] ifid_instr;
  logic [WORD_SIZE-1:0] ifid_pred_pc;

  modport master (
    output i_readM, i_address, bp_pc,
    output ifid_valid, ifid_pc, ifid_instr, ifid_pred_pc,
    input  i_data, i_ready, bp_predicted_pc,
    input  stall_id, redirect, redirect_pc
  );

  modport slave (
    input  i_readM, i_address, bp_pc,
    input  ifid_valid, ifid_pc, ifid_instr, ifid_pred_pc,
    output i_data, i_ready, bp_predicted_pc,
    output stall_id, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one instruction-memory request at a time,
// fills the IF/ID latch, parks a returned word in a one-entry hold buffer
// while ID stalls, and flushes on redirect.
// Build option: define FETCH_PREDICT_EN to take the next PC from the branch
// predictor; otherwise the next PC is the sequential address + 1.
//
// state | meaning
// WAIT  | first cycle after reset, no request outstanding
// FETCH | request in flight at req_addr, word will be used
// HOLD  | word parked in hold buffer, ID stalled, no request
// DROP  | request in flight whose word must be discarded (after redirect)
module fetch_unit #(
  parameter int                   WORD_SIZE = 16,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic           clk,
  input  logic           reset_n,
  fetch_unit_if.master   bus
);

  localparam logic [1:0] ST_WAIT  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_DROP  = 2'd3;

  logic [1:0]           state_q,      state_d;
  logic [WORD_SIZE-1:0] pc_q,         pc_d;
  logic [WORD_SIZE-1:0] req_addr_q,   req_addr_d;
  logic [WORD_SIZE-1:0] hold_instr_q, hold_instr_d;
  logic [WORD_SIZE-1:0] hold_pc_q,    hold_pc_d;
  logic [WORD_SIZE-1:0] hold_pred_q,  hold_pred_d;
  logic                 ifid_valid_q, ifid_valid_d;
  logic [WORD_SIZE-1:0] ifid_pc_q,    ifid_pc_d;
  logic [WORD_SIZE-1:0] ifid_instr_q, ifid_instr_d;
  logic [WORD_SIZE-1:0] ifid_pred_q,  ifid_pred_d;

  logic [WORD_SIZE-1:0] next_pc;
  logic                 ifid_free;
  logic                 new_req;

`ifdef FETCH_PREDICT_EN
  assign next_pc = bus.bp_predicted_pc;
`else
  // Predictor input is deliberately not consumed in the sequential build.
  logic [WORD_SIZE-1:0] unused_bp_pred;
  assign unused_bp_pred = bus.bp_predicted_pc;
  assign next_pc        = req_addr_q + {{(WORD_SIZE-1){1'b0}}, 1'b1};
`endif

  assign ifid_free = !ifid_valid_q || !bus.stall_id;

  // Next-state logic: redirect wins over delivery, hold release and bubbles.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    hold_pred_d  = hold_pred_q;
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pred_d  = ifid_pred_q;
    new_req      = 1'b0;

    if (ifid_free) begin
      ifid_valid_d = 1'b0;
    end

    case (state_q)
      ST_WAIT: begin
        state_d = ST_FETCH;
        new_req = 1'b1;
        if (bus.redirect) begin
          pc_d = bus.redirect_pc;
        end
      end
      ST_FETCH: begin
        if (bus.redirect) begin
          pc_d = bus.redirect_pc;
          if (bus.i_ready) begin
            new_req = 1'b1;
          end else begin
            state_d = ST_DROP;
          end
        end else if (bus.i_ready) begin
          if (ifid_free) begin
            ifid_valid_d = 1'b1;
            ifid_pc_d    = req_addr_q;
            ifid_instr_d = bus.i_data;
            ifid_pred_d  = next_pc;
            pc_d         = next_pc;
            new_req      = 1'b1;
          end else begin
            hold_instr_d = bus.i_data;
            hold_pc_d    = req_addr_q;
            hold_pred_d  = next_pc;
            state_d      = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (bus.redirect) begin
          pc_d    = bus.redirect_pc;
          state_d = ST_FETCH;
          new_req = 1'b1;
        end else if (ifid_free) begin
          ifid_valid_d = 1'b1;
          ifid_pc_d    = hold_pc_q;
          ifid_instr_d = hold_instr_q;
          ifid_pred_d  = hold_pred_q;
          pc_d         = hold_pred_q;
          state_d      = ST_FETCH;
          new_req      = 1'b1;
        end
      end
      default: begin
        // ST_DROP: the outstanding word is never used.
        if (bus.redirect) begin
          pc_d = bus.redirect_pc;
        end
        if (bus.i_ready) begin
          state_d = ST_FETCH;
          new_req = 1'b1;
        end
      end
    endcase

    if (bus.redirect) begin
      ifid_valid_d = 1'b0;
      hold_instr_d = '0;
      hold_pc_d    = '0;
      hold_pred_d  = '0;
    end

    if (new_req) begin
      req_addr_d = pc_d;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_WAIT;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
      hold_pred_q  <= '0;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= '0;
      ifid_pred_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      hold_pred_q  <= hold_pred_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pred_q  <= ifid_pred_d;
    end
  end

  assign bus.i_readM      = (state_q == ST_FETCH) || (state_q == ST_DROP);
  assign bus.i_address    = req_addr_q;
  assign bus.bp_pc        = req_addr_q;
  assign bus.ifid_valid   = ifid_valid_q;
  assign bus.ifid_pc      = ifid_pc_q;
  assign bus.ifid_instr   = ifid_instr_q;
  assign bus.ifid_pred_pc = ifid_pred_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed stimulus pushes expected IF/ID
// entries; a monitor pops one each time ID consumes the latch.
module tb_fetch_unit;
  localparam int W = 16;
`ifdef FETCH_PREDICT_EN
  localparam logic [15:0] P34 = 16'h0040;
`else
  localparam logic [15:0] P34 = 16'h0003;
`endif

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] pred;
  } ifid_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if #(.WORD_SIZE(W)) bus ();

  fetch_unit #(.WORD_SIZE(W), .RESET_PC(16'h0000)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  int    tests = 0;
  int    fails = 0;
  ifid_t exp_q[$];
  int    lat = 1;
  int    cnt = 0;
  bit    pred_on = 1'b0;
  bit    force_ready = 1'b0;

  function automatic logic [15:0] imem(input logic [15:0] a);
    return a ^ 16'h5A00;
  endfunction

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] pc, input logic [15:0] pred);
    ifid_t e;
    e.pc    = pc;
    e.instr = imem(pc);
    e.pred  = pred;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_readM"},  {47'd0, bus.i_readM},    48'd0);
    check({tag, "_addr"},   {32'd0, bus.i_address},  48'd0);
    check({tag, "_bp_pc"},  {32'd0, bus.bp_pc},      48'd0);
    check({tag, "_valid"},  {47'd0, bus.ifid_valid}, 48'd0);
    check({tag, "_ifid"},   {bus.ifid_pc, bus.ifid_instr, bus.ifid_pred_pc}, 48'd0);
  endtask

  // Memory and predictor model: i_ready after 'lat' cycles of a held request.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (force_ready) begin
        bus.i_ready = 1'b1;
        bus.i_data  = 16'hDEAD;
        cnt         = 0;
      end else if (bus.i_readM) begin
        cnt++;
        if (cnt >= lat) begin
          bus.i_ready = 1'b1;
          bus.i_data  = imem(bus.i_address);
          cnt         = 0;
        end else begin
          bus.i_ready = 1'b0;
        end
      end else begin
        bus.i_ready = 1'b0;
        cnt         = 0;
      end
      bus.bp_predicted_pc = (pred_on && bus.bp_pc == 16'h0002) ? 16'h0040 : bus.bp_pc + 16'h0001;
    end
  end

  // Monitor: each cycle ID consumes a valid IF/ID entry, compare with scoreboard.
  initial begin
    ifid_t e;
    forever begin
      @(negedge clk);
      #2;
      if (bus.ifid_valid === 1'b1 && bus.stall_id === 1'b0) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL ifid_unexpected: got pc %h instr %h pred %h, expected no delivery",
                   bus.ifid_pc, bus.ifid_instr, bus.ifid_pred_pc);
        end else begin
          e = exp_q.pop_front();
          check("ifid_entry", {bus.ifid_pc, bus.ifid_instr, bus.ifid_pred_pc}, e);
        end
      end
    end
  end

  initial begin
    bus.i_ready         = 1'b0;
    bus.i_data          = '0;
    bus.bp_predicted_pc = '0;
    bus.stall_id        = 1'b0;
    bus.redirect        = 1'b0;
    bus.redirect_pc     = '0;

    repeat (2) tick();
    check_reset_values("rst0");
    push(16'h0000, 16'h0001);
    push(16'h0001, 16'h0002);
    push(16'h0002, 16'h0003);
    push(16'h0003, 16'h0004);
    push(16'h0004, 16'h0005);
    reset_n = 1'b1;

    // Back-to-back fetch with single-cycle memory.
    tick(); check("seq_readM", {47'd0, bus.i_readM}, 48'd1);
            check("seq_addr0", {32'd0, bus.i_address}, 48'h0000);
    tick(); check("seq_addr1", {32'd0, bus.i_address}, 48'h0001);
    tick(); check("seq_addr2", {32'd0, bus.i_address}, 48'h0002);
    tick(); check("seq_addr3", {32'd0, bus.i_address}, 48'h0003);
    bus.stall_id = 1'b1;

    // Three stalled cycles: IF/ID frozen, next word parked, no request.
    tick(); check("stall_readM", {47'd0, bus.i_readM}, 48'd0);
            check("stall_ifid", {bus.ifid_pc, bus.ifid_instr, bus.ifid_pred_pc},
                  {16'h0002, imem(16'h0002), 16'h0003});
    tick(); check("stall_valid", {47'd0, bus.ifid_valid}, 48'd1);
            check("stall_pc", {32'd0, bus.ifid_pc}, 48'h0002);
    tick(); check("stall_readM3", {47'd0, bus.i_readM}, 48'd0);
    bus.stall_id = 1'b0;
    tick(); check("release_addr", {32'd0, bus.i_address}, 48'h0004);
            check("release_readM", {47'd0, bus.i_readM}, 48'd1);

    // Redirect with same-cycle i_ready, then predicted target for pc 2.
    tick(); check("pre_redir_addr", {32'd0, bus.i_address}, 48'h0005);
    bus.redirect = 1'b1; bus.redirect_pc = 16'h0002; pred_on = 1'b1;
    push(16'h0002, P34);
    push(P34, P34 + 16'h0001);
    tick(); bus.redirect = 1'b0;
            check("redir_addr", {32'd0, bus.i_address}, 48'h0002);
            check("redir_valid", {47'd0, bus.ifid_valid}, 48'd0);
    tick(); check("pred_addr", {32'd0, bus.i_address}, {32'd0, P34});
    pred_on = 1'b0;

    // Three-cycle memory, redirect in the first request cycle.
    tick(); check("drop_req_addr", {32'd0, bus.i_address}, {32'd0, P34 + 16'h0001});
    lat = 3;
    bus.redirect = 1'b1; bus.redirect_pc = 16'h0100;
    push(16'h0100, 16'h0101);
    tick(); bus.redirect = 1'b0;
            check("drop_readM", {47'd0, bus.i_readM}, 48'd1);
            check("drop_addr1", {32'd0, bus.i_address}, {32'd0, P34 + 16'h0001});
            check("drop_valid1", {47'd0, bus.ifid_valid}, 48'd0);
    tick(); check("drop_addr2", {32'd0, bus.i_address}, {32'd0, P34 + 16'h0001});
            check("drop_valid2", {47'd0, bus.ifid_valid}, 48'd0);
    tick(); check("drop_new_addr", {32'd0, bus.i_address}, 48'h0100);
            check("drop_valid3", {47'd0, bus.ifid_valid}, 48'd0);
    repeat (3) tick();
    check("slow_next_addr", {32'd0, bus.i_address}, 48'h0101);

    // Redirect coinciding with i_ready, then redirect while holding a word.
    repeat (2) tick();
    bus.redirect = 1'b1; bus.redirect_pc = 16'h0200;
    push(16'h0200, 16'h0201);
    push(16'h0300, 16'h0301);
    tick(); bus.redirect = 1'b0;
            check("same_cyc_addr", {32'd0, bus.i_address}, 48'h0200);
            check("same_cyc_valid", {47'd0, bus.ifid_valid}, 48'd0);
    repeat (3) tick();
    check("hold_ifid_pc", {32'd0, bus.ifid_pc}, 48'h0200);
    bus.stall_id = 1'b1;
    repeat (3) tick();
    check("hold_readM", {47'd0, bus.i_readM}, 48'd0);
    bus.stall_id = 1'b0;
    bus.redirect = 1'b1; bus.redirect_pc = 16'h0300;
    tick(); bus.redirect = 1'b0;
            check("hold_redir_addr", {32'd0, bus.i_address}, 48'h0300);
            check("hold_redir_valid", {47'd0, bus.ifid_valid}, 48'd0);
            check("hold_redir_readM", {47'd0, bus.i_readM}, 48'd1);
    lat = 1;

    // Address wrap at 16'hFFFF.
    tick(); bus.redirect = 1'b1; bus.redirect_pc = 16'hFFFF;
    push(16'hFFFF, 16'h0000);
    push(16'h0000, 16'h0001);
    tick(); bus.redirect = 1'b0;
            check("wrap_addr_ffff", {32'd0, bus.i_address}, 48'hFFFF);
    tick(); check("wrap_addr_0000", {32'd0, bus.i_address}, 48'h0000);

    // Reset in the middle of a slow request, then a stray i_ready in WAIT.
    tick(); lat = 3; reset_n = 1'b0;
    tick(); check_reset_values("rst1");
    force_ready = 1'b1; reset_n = 1'b1;
    push(16'h0000, 16'h0001);
    tick(); force_ready = 1'b0;
            check("wait_ignore_valid", {47'd0, bus.ifid_valid}, 48'd0);
            check("wait_ignore_addr", {32'd0, bus.i_address}, 48'h0000);
            check("wait_ignore_readM", {47'd0, bus.i_readM}, 48'd1);
    repeat (4) tick();
    bus.stall_id = 1'b1;
    repeat (4) tick();

    check("scoreboard_drained", {16'd0, 32'(exp_q.size())}, 48'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
